// File: rtl/dap_pkg.sv
// Shared definitions for the dap S00_AXI register slave.
package dap_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Image-filter control map (register index, not byte address)
    localparam int REG_CTRL   = 0;
    localparam int REG_WIDTH  = 1;
    localparam int REG_HEIGHT = 2;
    localparam int REG_COEF   = 3;

endpackage

// File: rtl/dap_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the S00_AXI port.
interface dap_s00_axi_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/dap_axil_wr_merge.sv
// Write-channel merge: captures AW and W independently, produces a single
// commit when both are available, and sequences the B response.
module dap_axil_wr_merge #(
    parameter int IW       = 2,
    parameter int DW       = 32,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [IW-1:0]     awidx,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    output logic [1:0]        bresp,
    input  logic              bready,
    output logic              commit,
    output logic              commit_ok,
    output logic [IW-1:0]     commit_idx,
    output logic [DW-1:0]     commit_data,
    output logic [DW/8-1:0]   commit_strb
);
    import dap_pkg::*;

    logic            aw_held;
    logic            w_held;
    logic [IW-1:0]   idx_q;
    logic [DW-1:0]   data_q;
    logic [DW/8-1:0] strb_q;
    logic            aw_hs;
    logic            w_hs;

    // A pending response blocks both channels so only one write is in flight
    assign awready = en && !aw_held && !bvalid;
    assign wready  = en && !w_held && !bvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Either half may come from its holding register or the live bus this edge
    assign commit      = (aw_held || aw_hs) && (w_held || w_hs);
    assign commit_idx  = aw_held ? idx_q  : awidx;
    assign commit_data = w_held  ? data_q : wdata;
    assign commit_strb = w_held  ? strb_q : wstrb;
    assign commit_ok   = {{(32-IW){1'b0}}, commit_idx} < 32'(NUM_REGS);

    // Channel capture, commit and B-channel handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                idx_q   <= awidx;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                data_q <= wdata;
                strb_q <= wstrb;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dap_s00_axi_regs.sv
// AXI4-Lite register file terminating S00_AXI of the dap IP; exports the
// control registers and per-register write strobes to the filter datapath.
module dap_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                                 s00_axi_aclk,
    input  logic                                 s00_axi_aresetn,
    dap_s00_axi_regs_if.slave                    s00_axi,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [C_NUM_REGS-1:0]                reg_wr
);
    import dap_pkg::*;

    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic                rst_done;
    logic                commit;
    logic                commit_ok;
    logic [IW-1:0]       commit_idx;
    logic [DW-1:0]       commit_data;
    logic [DW/8-1:0]     commit_strb;
    rd_state_t           state_q;
    rd_state_t           state_d;
    logic [IW-1:0]       ar_idx;
    logic                ar_hs;
    logic                rd_ok;
    logic [DW-1:0]       rd_word;
    logic                unused_bits;

    // prot and the byte-offset address bits carry no meaning here
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    // Ready outputs stay low until the first edge after reset release
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) rst_done <= 1'b0;
        else                  rst_done <= 1'b1;
    end

    dap_axil_wr_merge #(
        .IW       (IW),
        .DW       (DW),
        .NUM_REGS (C_NUM_REGS)
    ) u_wr_merge (
        .clk         (s00_axi_aclk),
        .rst_n       (s00_axi_aresetn),
        .en          (rst_done),
        .awidx       (s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2]),
        .awvalid     (s00_axi.awvalid),
        .awready     (s00_axi.awready),
        .wdata       (s00_axi.wdata),
        .wstrb       (s00_axi.wstrb),
        .wvalid      (s00_axi.wvalid),
        .wready      (s00_axi.wready),
        .bvalid      (s00_axi.bvalid),
        .bresp       (s00_axi.bresp),
        .bready      (s00_axi.bready),
        .commit      (commit),
        .commit_ok   (commit_ok),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    // Register array: byte-lane update on commit, write strobe one cycle later
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            reg_q  <= '0;
            reg_wr <= '0;
        end else begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                reg_wr[k] <= commit && commit_ok && (commit_idx == IW'(k));
                if (commit && commit_ok && (commit_idx == IW'(k))) begin
                    for (int b = 0; b < DW/8; b++) begin
                        if (commit_strb[b]) begin
                            reg_q[k*DW + 8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_ok  = {{(32-IW){1'b0}}, ar_idx} < 32'(C_NUM_REGS);
    assign ar_hs  = s00_axi.arvalid && s00_axi.arready;

    // Read mux; unimplemented indices read as zero
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (ar_idx == IW'(k)) rd_word = reg_q[k*DW +: DW];
        end
    end

    // Read FSM state register
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state_q <= R_IDLE;
        else                  state_q <= state_d;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        state_d         = state_q;
        s00_axi.arready = 1'b0;
        s00_axi.rvalid  = 1'b0;
        case (state_q)
            R_IDLE: begin
                s00_axi.arready = rst_done;
                if (s00_axi.arvalid && rst_done) state_d = R_DATA;
            end
            R_DATA: begin
                s00_axi.rvalid = 1'b1;
                if (s00_axi.rready) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Read data captured at the AR handshake and held until accepted
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi.rdata <= '0;
            s00_axi.rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s00_axi.rdata <= rd_word;
            s00_axi.rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end
endmodule

// File: tb/tb_dap_s00_axi_regs.sv
// Directed bench: two register files (4 and 2 registers) share one stimulus.
module tb_dap_s00_axi_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] reg_q_a;
    logic [3:0]   reg_wr_a;
    logic [63:0]  reg_q_b;
    logic [1:0]   reg_wr_b;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cnt_a [4];
    int           cnt_b [2];

    dap_s00_axi_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_a ();
    dap_s00_axi_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_b ();

    assign bus_b.awaddr  = bus_a.awaddr;
    assign bus_b.awprot  = bus_a.awprot;
    assign bus_b.awvalid = bus_a.awvalid;
    assign bus_b.wdata   = bus_a.wdata;
    assign bus_b.wstrb   = bus_a.wstrb;
    assign bus_b.wvalid  = bus_a.wvalid;
    assign bus_b.bready  = bus_a.bready;
    assign bus_b.araddr  = bus_a.araddr;
    assign bus_b.arprot  = bus_a.arprot;
    assign bus_b.arvalid = bus_a.arvalid;
    assign bus_b.rready  = bus_a.rready;

    dap_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_NUM_REGS(4)) dut_a (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus_a),
        .reg_q           (reg_q_a),
        .reg_wr          (reg_wr_a)
    );

    dap_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .C_NUM_REGS(2)) dut_b (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus_b),
        .reg_q           (reg_q_b),
        .reg_wr          (reg_wr_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) cnt_a[k] += int'(reg_wr_a[k]);
        for (int k = 0; k < 2; k++) cnt_b[k] += int'(reg_wr_b[k]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic write_issue(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_done = 1'b0;
        logic w_done  = 1'b0;
        logic aw_now;
        logic w_now;
        int   n = 0;
        bus_a.awaddr  = addr;
        bus_a.wdata   = data;
        bus_a.wstrb   = strb;
        bus_a.awvalid = 1'b1;
        bus_a.wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = bus_a.awvalid && bus_a.awready;
            w_now  = bus_a.wvalid && bus_a.wready;
            @(posedge clk); #1;
            n++;
            if (aw_now) begin aw_done = 1'b1; bus_a.awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; bus_a.wvalid  = 1'b0; end
        end
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        if (!(aw_done && w_done)) check_eq("wr_handshake_timeout", {aw_done, w_done}, 2'b11);
    endtask

    task automatic write_resp(output logic [1:0] resp_a, output logic [1:0] resp_b);
        int n = 0;
        bus_a.bready = 1'b1;
        while (!bus_a.bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_a.bvalid) check_eq("bvalid_timeout", bus_a.bvalid, 1'b1);
        resp_a = bus_a.bresp;
        resp_b = bus_b.bresp;
        @(posedge clk); #1;
        bus_a.bready = 1'b0;
    endtask

    task automatic read_issue(input logic [3:0] addr);
        logic done = 1'b0;
        logic now;
        int   n = 0;
        bus_a.araddr  = addr;
        bus_a.arvalid = 1'b1;
        while (!done && n < 20) begin
            now = bus_a.arvalid && bus_a.arready;
            @(posedge clk); #1;
            n++;
            if (now) begin done = 1'b1; bus_a.arvalid = 1'b0; end
        end
        bus_a.arvalid = 1'b0;
        if (!done) check_eq("rd_handshake_timeout", done, 1'b1);
    endtask

    task automatic read_resp(output logic [31:0] data_a, output logic [1:0] resp_a,
                             output logic [31:0] data_b, output logic [1:0] resp_b);
        int n = 0;
        bus_a.rready = 1'b1;
        while (!bus_a.rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_a.rvalid) check_eq("rvalid_timeout", bus_a.rvalid, 1'b1);
        data_a = bus_a.rdata;
        resp_a = bus_a.rresp;
        data_b = bus_b.rdata;
        resp_b = bus_b.rresp;
        @(posedge clk); #1;
        bus_a.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  ra, rb;
        logic [31:0] da, db;
        int          snap_b;
        logic        b_seen;

        rst_n         = 1'b0;
        bus_a.awaddr  = '0;
        bus_a.awprot  = '0;
        bus_a.awvalid = 1'b0;
        bus_a.wdata   = '0;
        bus_a.wstrb   = '0;
        bus_a.wvalid  = 1'b0;
        bus_a.bready  = 1'b0;
        bus_a.araddr  = '0;
        bus_a.arprot  = '0;
        bus_a.arvalid = 1'b0;
        bus_a.rready  = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_readies", {bus_a.awready, bus_a.wready, bus_a.arready}, 3'b000);
        check_eq("rst_valids", {bus_a.bvalid, bus_a.rvalid, bus_a.bresp, bus_a.rresp}, 6'b0);
        check_eq("rst_rdata", bus_a.rdata, 32'h0);
        check_eq("rst_regs", {reg_q_a, reg_wr_a}, 132'h0);
        rst_n = 1'b1;
        #1;
        check_eq("release_ready_low", {bus_a.awready, bus_a.wready, bus_a.arready}, 3'b000);
        @(posedge clk); #1;
        check_eq("release_ready_high", {bus_a.awready, bus_a.wready, bus_a.arready}, 3'b111);

        // Four writes then readback
        for (int i = 0; i < 4; i++) begin
            write_issue(4'(i*4), 32'(i+1), 4'hF);
            write_resp(ra, rb);
            check_eq($sformatf("wr%0d_bresp", i), ra, 2'b00);
            check_eq($sformatf("wr%0d_bresp_n2", i), rb, (i < 2) ? 2'b00 : 2'b10);
        end
        for (int i = 0; i < 4; i++) begin
            read_issue(4'(i*4));
            read_resp(da, ra, db, rb);
            check_eq($sformatf("rd%0d_data", i), da, 32'(i+1));
            check_eq($sformatf("rd%0d_rresp", i), ra, 2'b00);
        end
        for (int k = 0; k < 4; k++) check_eq($sformatf("reg_wr_cnt%0d", k), 32'(cnt_a[k]), 32'd1);
        check_eq("reg_wr_cnt_n2", {32'(cnt_b[1]), 32'(cnt_b[0])}, {32'd1, 32'd1});

        // Same-edge AW+W: register updated at the edge, bvalid the cycle after
        write_issue(4'h0, 32'h11223344, 4'hF);
        check_eq("lat_bvalid", bus_a.bvalid, 1'b1);
        check_eq("lat_reg0", reg_q_a[31:0], 32'h11223344);
        write_resp(ra, rb);

        // Byte strobes
        write_issue(4'h0, 32'hAABBCCDD, 4'b0101);
        write_resp(ra, rb);
        read_issue(4'h0);
        read_resp(da, ra, db, rb);
        check_eq("strb_rdata", da, 32'h11BB33DD);

        // W three cycles ahead of AW
        bus_a.awaddr = 4'h8;
        bus_a.wdata  = 32'hCAFE0000;
        bus_a.wstrb  = 4'hF;
        bus_a.wvalid = 1'b1;
        @(posedge clk); #1;
        bus_a.wvalid = 1'b0;
        check_eq("wfirst_wready", bus_a.wready, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("wfirst_no_bvalid", {bus_a.bvalid, reg_q_a[95:64]}, {1'b0, 32'h3});
        bus_a.awvalid = 1'b1;
        @(posedge clk); #1;
        bus_a.awvalid = 1'b0;
        check_eq("wfirst_bvalid", bus_a.bvalid, 1'b1);
        check_eq("wfirst_reg2", reg_q_a[95:64], 32'hCAFE0000);
        write_resp(ra, rb);
        check_eq("wfirst_bresp", ra, 2'b00);

        // Read and write of the same register on the same edge
        bus_a.awaddr  = 4'h4;
        bus_a.wdata   = 32'h77;
        bus_a.wstrb   = 4'hF;
        bus_a.araddr  = 4'h4;
        bus_a.awvalid = 1'b1;
        bus_a.wvalid  = 1'b1;
        bus_a.arvalid = 1'b1;
        @(posedge clk); #1;
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        bus_a.arvalid = 1'b0;
        check_eq("rw_same_reg1", reg_q_a[63:32], 32'h77);
        read_resp(da, ra, db, rb);
        check_eq("rw_same_rdata_old", da, 32'h2);
        write_resp(ra, rb);

        // Back-pressure on both response channels
        write_issue(4'hC, 32'h5A5A5A5A, 4'hF);
        read_issue(4'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("bp%0d_flags", c),
                     {bus_a.bvalid, bus_a.rvalid, bus_a.awready, bus_a.wready, bus_a.arready},
                     5'b11000);
            check_eq($sformatf("bp%0d_payload", c),
                     {bus_a.rdata, bus_a.rresp, bus_a.bresp}, {32'h11BB33DD, 2'b00, 2'b00});
        end
        read_resp(da, ra, db, rb);
        write_resp(ra, rb);
        check_eq("bp_reg3", reg_q_a[127:96], 32'h5A5A5A5A);

        // Out-of-range index on the two-register instance
        snap_b = cnt_b[0] + cnt_b[1];
        write_issue(4'h8, 32'hFFFFFFFF, 4'hF);
        write_resp(ra, rb);
        check_eq("oor_bresp_n2", rb, 2'b10);
        check_eq("oor_bresp_n4", ra, 2'b00);
        read_issue(4'h8);
        read_resp(da, ra, db, rb);
        check_eq("oor_read_n2", {db, rb}, {32'h0, 2'b10});
        check_eq("oor_read_n4", {da, ra}, {32'hFFFFFFFF, 2'b00});
        check_eq("oor_regs_n2", reg_q_b, {32'h77, 32'h11BB33DD});
        @(posedge clk); #1;
        check_eq("oor_no_reg_wr_n2", 32'(cnt_b[0] + cnt_b[1]), 32'(snap_b));

        // Reset one cycle after a lone AW handshake
        bus_a.awaddr  = 4'h4;
        bus_a.awvalid = 1'b1;
        @(posedge clk); #1;
        bus_a.awvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_regs", reg_q_a, 128'h0);
        check_eq("midrst_flags", {bus_a.bvalid, bus_a.awready, bus_a.wready}, 3'b000);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus_a.wdata   = 32'h99;
        bus_a.wstrb   = 4'hF;
        bus_a.wvalid  = 1'b1;
        bus_a.bready  = 1'b1;
        b_seen        = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus_a.bvalid) b_seen = 1'b1;
            if (!bus_a.wready) bus_a.wvalid = 1'b0;
        end
        check_eq("midrst_no_bvalid", b_seen, 1'b0);
        check_eq("midrst_regs_after", reg_q_a, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dap_s00_axi_regs.md
# dap_s00_axi_regs

AXI4-Lite slave register file that terminates the S00_AXI interface of the dap IP. It is the responder counterpart to the bench's AXI4-Lite master VIP, which issues single-beat writes and reads. It holds C_NUM_REGS 32-bit control registers, applies byte strobes, and exports register contents plus per-register write pulses to the image-filter datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width; register index is addr[C_S_AXI_ADDR_WIDTH-1:2].
- C_NUM_REGS, 4: number of implemented registers, 1..2^(C_S_AXI_ADDR_WIDTH-2).
- s00_axi_aclk  in  1  single clock; all logic is on the rising edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  write response: OKAY=2'b00, SLVERR=2'b10.
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- reg_q  out  C_NUM_REGS*32  register contents; register k is at [32k+31:32k].
- reg_wr  out  C_NUM_REGS  one-cycle strobe for each committed write to register k.

## Operation
- Write path: the AW and W channels are accepted independently and latched into aw_held and w_held flags with their payloads.
- awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
- Commit happens at the edge where both AW and W are available, either already held or handshaking on that edge:
  - in-range index: byte lanes with wstrb[b]=1 are updated, reg_wr[idx] is pulsed in the next cycle, and bresp=OKAY;
  - out-of-range index (idx ≥ C_NUM_REGS): no register change, no reg_wr pulse, bresp=SLVERR.
- After commit, bvalid is held high until bready. The held flags clear at commit.
- Read path has two states, R_IDLE and R_DATA:
  - arready=1 only in R_IDLE;
  - on the AR handshake, rdata and rresp are captured and the state moves to R_DATA with rvalid=1;
  - on rvalid && rready, the state returns to R_IDLE.
- Out-of-range read returns rdata=0 and rresp=SLVERR.
- Read and write paths are independent; at most one write and one read are outstanding at a time.

## Timing
- Reset values: awready=wready=arready=0 while reset is asserted, and 1 from the first edge after release. bvalid=rvalid=0, bresp=rresp=0, rdata=0, all registers 0, reg_wr=0.
- Write latency: AW and W both handshaking at edge N gives register update at edge N and bvalid=1 in cycle N+1. If W arrives k cycles after AW, bvalid rises one cycle after the W handshake.
- Back-to-back writes: with bready held at 1, a new AW/W pair may handshake in the cycle after bvalid falls, so steady-state throughput is one write per 2 cycles.
- Read latency: AR handshake at edge N gives rvalid=1 and rdata stable in cycle N+1. rdata holds until the rready handshake.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Back-pressure: bvalid, bresp, rvalid, rdata and rresp do not change while the master holds ready low.
- Reset asserted mid-transaction: all held flags, pending responses and registers clear immediately. The in-flight transaction is dropped.

## Structure
- Shared package dap_pkg: AXI response constants (RESP_OKAY, RESP_SLVERR), the read FSM state enum, and the register index constants for the filter control map.
- One natural sub-module: dap_axil_wr_merge. It performs AW/W capture, commit generation and B-channel sequencing. The read FSM and register array stay in the top.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back -> each read returns the written value with rresp=OKAY, and one reg_wr pulse occurs per write.
- Write 0xAABBCCDD to 0x0 with wstrb=4'b0101 over a prior value of 0x11223344 -> readback is 0x11BB33DD.
- Present W three cycles before AW to 0x8 with data 0xCAFE0000 -> wready drops after the W handshake, and bvalid rises one cycle after the AW handshake; reg_q[95:64]=0xCAFE0000.
- Hold bready=0 and rready=0 for 5 cycles after a write and a read -> bvalid and rvalid stay high with stable rdata, and awready, wready and arready stay 0.
- With C_NUM_REGS=2, write and read 0x8 -> bresp=SLVERR, rresp=SLVERR, rdata=0, and no reg_wr pulse.
- Assert aresetn low one cycle after the AW handshake to 0x4 -> bvalid never rises and reg_q reads all-zero after reset.
